// File: rtl/mem_block_mover_pkg.sv
// Shared definitions for the memory block mover: state encoding and default widths.
package mem_block_mover_pkg;

  localparam int unsigned MOVER_ADDR_W = 12;
  localparam int unsigned MOVER_WORD_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } Mover_states_t;

endpackage

// File: rtl/mem_block_mover.sv
// Bus master that copies a block of words one read/write pair at a time, ascending order.
// Optional running checksum of written words when MEM_MOVER_CHECKSUM_EN is defined.
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int unsigned ADDR_W = MOVER_ADDR_W,
  parameter int unsigned WORD_W = MOVER_WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] address,
  output logic              read_enable,
  output logic              write_enable,
  output logic [WORD_W-1:0] write_data,
`ifdef MEM_MOVER_CHECKSUM_EN
  output logic [WORD_W-1:0] checksum,
`endif
  input  logic [WORD_W-1:0] read_data,
  input  logic              mem_finished
);

  Mover_states_t state_q, state_d;

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] dp_q, dp_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              abort_q, abort_d;
  logic              aborted_q, aborted_d;
  logic              abort_hit;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [WORD_W-1:0] write_data_q, write_data_d;

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    dp_d      = dp_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    aborted_d = aborted_q;
    // An abort arriving in the same cycle as the completion still counts.
    abort_hit = abort_q | (abort & busy_q);
    abort_d   = abort_hit;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          aborted_d = 1'b0;
          if (length != '0) begin
            sp_d    = src_addr;
            dp_d    = dst_addr;
            rem_d   = length;
            state_d = RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      RD: begin
        if (mem_finished) begin
          hold_d = read_data;
          if (abort_hit) begin
            aborted_d = 1'b1;
            state_d   = FIN;
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        if (mem_finished) begin
          sp_d  = sp_q + ADDR_W'(1);
          dp_d  = dp_q + ADDR_W'(1);
          rem_d = rem_q - (ADDR_W + 1)'(1);
          if (abort_hit) begin
            aborted_d = 1'b1;
          end
          if (abort_hit || rem_q == (ADDR_W + 1)'(1)) begin
            state_d = FIN;
          end else begin
            state_d = RD;
          end
        end
      end
      FIN: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d       = (state_d == RD) || (state_d == WR);
    done_d       = (state_d == FIN);
    re_d         = (state_d == RD);
    we_d         = (state_d == WR);
    address_d    = address_q;
    write_data_d = write_data_q;
    if (state_d == RD) begin
      address_d = sp_d;
    end else if (state_d == WR) begin
      address_d    = dp_d;
      write_data_d = hold_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sp_q         <= '0;
      dp_q         <= '0;
      rem_q        <= '0;
      hold_q       <= '0;
      abort_q      <= 1'b0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      dp_q         <= dp_d;
      rem_q        <= rem_d;
      hold_q       <= hold_d;
      abort_q      <= abort_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      re_q         <= re_d;
      we_q         <= we_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign address      = address_q;
  assign read_enable  = re_q;
  assign write_enable = we_q;
  assign write_data   = write_data_q;

`ifdef MEM_MOVER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && start) begin
      checksum_d = '0;
    end else if (state_q == WR && mem_finished) begin
      checksum_d = checksum_q + hold_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover: memory responder with random latency plus
// read/write scoreboards filled from a reference copy model.
module tb_mem_block_mover;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] src_addr = '0;
  logic [11:0] dst_addr = '0;
  logic [12:0] length = '0;
  logic        abort = 1'b0;
  logic [11:0] read_data = '0;
  logic        mem_finished = 1'b0;
  logic        busy, done, aborted, read_enable, write_enable;
  logic [11:0] address, write_data;
`ifdef MEM_MOVER_CHECKSUM_EN
  logic [11:0] checksum;
`endif

  mem_block_mover dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .address      (address),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .write_data   (write_data),
`ifdef MEM_MOVER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .read_data    (read_data),
    .mem_finished (mem_finished)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] mem [4096];
  logic [11:0] ref_mem [4096];
  logic [11:0] rd_q [$];
  logic [23:0] wr_q [$];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          cnt = 0;
  int          lat = 1;
  int          lat_max = 4;
  bit          mem_en = 1'b1;
  bit          mf_manual = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the falling edge, then let the memory responder act.
  task automatic cycle();
    logic [23:0] e;
    logic [11:0] ea;
    @(negedge clock);
    if (!mem_en) begin
      cnt = 0;
      mem_finished = mf_manual;
    end else if (mem_finished) begin
      mem_finished = 1'b0;
      cnt = 0;
      read_data = 12'($urandom);
    end else if (read_enable || write_enable) begin
      if (cnt == 0) lat = int'($urandom_range(32'(lat_max), 1));
      cnt++;
      if (cnt >= lat) begin
        mem_finished = 1'b1;
        if (write_enable) begin
          mem[address] = write_data;
          wr_cnt++;
          if (wr_q.size() == 0) check("write_unexpected", 32'(wr_q.size()), 32'd1);
          else begin
            e = wr_q.pop_front();
            check("write_addr_data", 32'({address, write_data}), 32'(e));
          end
        end else begin
          read_data = mem[address];
          rd_cnt++;
          if (rd_q.size() == 0) check("read_unexpected", 32'(rd_q.size()), 32'd1);
          else begin
            ea = rd_q.pop_front();
            check("read_addr", 32'(address), 32'(ea));
          end
        end
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic set_word(input logic [11:0] a, input logic [11:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic run(input logic [11:0] src, input logic [11:0] dst, input logic [12:0] len,
                     input int abort_read, input bit poke, input int budget);
    int          n_rd, n_wr, wr0, cycles, rd_req, mism;
    bit          prev_re, abort_sent, busy_ok, excl, mf_last;
    logic [11:0] a, d, cs;
    rd_q.delete();
    wr_q.delete();
    n_rd = int'(len);
    n_wr = int'(len);
    if (abort_read > 0) begin
      n_rd = abort_read;
      n_wr = abort_read - 1;
    end
    for (int i = 0; i < n_rd; i++) rd_q.push_back(src + 12'(i));
    cs = '0;
    for (int i = 0; i < n_wr; i++) begin
      d = ref_mem[src + 12'(i)];
      a = dst + 12'(i);
      ref_mem[a] = d;
      cs = cs + d;
      wr_q.push_back({a, d});
    end
    wr0 = wr_cnt;
    src_addr = src;
    dst_addr = dst;
    length = len;
    start = 1'b1;
    cycle();
    start = 1'b0;
    src_addr = ~src;
    dst_addr = ~dst;
    length = 13'd5;
    check("aborted_cleared", 32'(aborted), 32'd0);
    if (len != '0) begin
      check("accept_busy_re_we", 32'({busy, read_enable, write_enable}), 32'b110);
      check("accept_addr", 32'(address), 32'(src));
    end else begin
      check("zero_len_accept", 32'({busy, read_enable, write_enable, done}), 32'b0001);
    end
    cycles = 0;
    rd_req = 0;
    prev_re = 1'b0;
    abort_sent = 1'b0;
    busy_ok = 1'b1;
    excl = 1'b1;
    mf_last = 1'b0;
    while (!done && cycles < budget) begin
      if (read_enable && !prev_re) rd_req++;
      prev_re = read_enable;
      abort = (abort_read != 0) && (rd_req == abort_read) && read_enable && !abort_sent;
      if (abort) abort_sent = 1'b1;
      start = poke && (cycles == 3);
      if (read_enable && write_enable) excl = 1'b0;
      if (!busy) busy_ok = 1'b0;
      mf_last = mem_finished;
      cycle();
      cycles++;
    end
    abort = 1'b0;
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("enables_at_done", 32'({read_enable, write_enable}), 32'd0);
    if (len != '0) begin
      check("busy_throughout", 32'(busy_ok), 32'd1);
      check("enables_exclusive", 32'(excl), 32'd1);
      check("done_after_completion", 32'(mf_last), 32'd1);
    end
    check("aborted_flag", 32'(aborted), 32'(abort_read != 0));
`ifdef MEM_MOVER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(cs));
`endif
    cycle();
    check("done_one_pulse", 32'(done), 32'd0);
    check("write_count", 32'(wr_cnt - wr0), 32'(n_wr));
    check("scoreboard_drained", 32'(rd_q.size() + wr_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image", 32'(mism), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 12'($urandom);
      mem[i] = ref_mem[i];
    end

    // Reset values
    reset = 1'b1;
    cycle();
    cycle();
    check("reset_flags", 32'({busy, done, aborted, read_enable, write_enable}), 32'd0);
    check("reset_address", 32'(address), 32'd0);
    check("reset_write_data", 32'(write_data), 32'd0);
`ifdef MEM_MOVER_CHECKSUM_EN
    check("reset_checksum", 32'(checksum), 32'd0);
`endif
    reset = 1'b0;
    abort = 1'b1;  // abort while idle must be ignored
    cycle();
    abort = 1'b0;
    cycle();

    // Basic copy
    set_word(12'o0100, 12'o1111);
    set_word(12'o0101, 12'o2222);
    set_word(12'o0102, 12'o3333);
    set_word(12'o0103, 12'o4444);
    run(12'o0100, 12'o0200, 13'd4, 0, 1'b0, 200);
    check("basic_dst0", 32'(mem[12'o0200]), 32'o1111);
    check("basic_dst3", 32'(mem[12'o0203]), 32'o4444);

    // Zero length, with a stray completion pulse while idle
    mem_en = 1'b0;
    mf_manual = 1'b1;
    cycle();
    mf_manual = 1'b0;
    cycle();
    mem_en = 1'b1;
    check("stray_mf_idle", 32'({busy, read_enable, write_enable}), 32'd0);
    run(12'o0500, 12'o0600, 13'd0, 0, 1'b0, 5);

    // Address wrap on the source pointer
    run(12'o7776, 12'o0010, 13'd4, 0, 1'b0, 200);

    // Abort during the third read, then a fresh start clears the flag
    run(12'o1000, 12'o2000, 13'd8, 3, 1'b0, 400);
    run(12'o1100, 12'o2100, 13'd1, 0, 1'b0, 100);

    // Forward overlap propagates; a start while busy is ignored
    run(12'o0300, 12'o0301, 13'd6, 0, 1'b1, 400);

    // Reset in the middle of a write
    rd_q.delete();
    wr_q.delete();
    rd_q.push_back(12'o3000);
    src_addr = 12'o3000;
    dst_addr = 12'o3100;
    length = 13'd2;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (!write_enable && n < 50) begin
      cycle();
      n++;
    end
    check("reached_write", 32'(write_enable), 32'd1);
    mem_en = 1'b0;
    reset = 1'b1;
    cycle();
    check("midwr_reset_outputs", 32'({busy, done, read_enable, write_enable}), 32'd0);
    reset = 1'b0;
    mf_manual = 1'b1;
    cycle();
    mf_manual = 1'b0;
    cycle();
    cycle();
    check("late_mf_ignored", 32'({busy, done, read_enable, write_enable}), 32'd0);
    check("late_mf_address", 32'(address), 32'd0);
    check("no_write_after_reset", 32'(mem[12'o3100]), 32'(ref_mem[12'o3100]));
    mem_en = 1'b1;
    rd_q.delete();

    // Recovery after reset
    run(12'o3000, 12'o3100, 13'd3, 0, 1'b0, 200);

    // Words summing to zero modulo 2^12
    set_word(12'o0400, 12'o7777);
    set_word(12'o0401, 12'o0001);
    run(12'o0400, 12'o0500, 13'd2, 0, 1'b0, 100);
`ifdef MEM_MOVER_CHECKSUM_EN
    check("checksum_wraps_to_zero", 32'(checksum), 32'd0);
`endif

    // Whole field, destination region wraps through the source
    lat_max = 1;
    run(12'o0000, 12'o4000, 13'd4096, 0, 1'b0, 20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Bus-master block that issues read and write requests to the memory controller over the `main_bus` memory signals. It copies a block of 12-bit words from a source address to a destination address, one word at a time. It is the initiating end of the memory handshake, alongside the CPU and Controller. Software-visible uses are front-panel block copy and testbench preload/relocate of program images.

## Interface
Parameters:
- `ADDR_W`, 12: memory address width (one 4K field).
- `WORD_W`, 12: data word width.

Ports:
- `clock`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transfer. Sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source word. Captured on accepted `start`.
- `dst_addr`  in  ADDR_W  first destination word. Captured on accepted `start`.
- `length`  in  ADDR_W+1  word count, 0..4096.
- `abort`  in  1  stop after the in-flight access completes.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `aborted`  out  1  sticky. Last transfer ended by `abort`. Cleared on the next accepted `start`.
- `address`  out  ADDR_W  memory request address.
- `read_enable`  out  1  read request.
- `write_enable`  out  1  write request.
- `write_data`  out  WORD_W  write data.
- `read_data`  in  WORD_W  valid in the cycle `mem_finished`=1 during a read.
- `mem_finished`  in  1  one-cycle completion pulse from the memory controller.

## Operation
- States:
  - IDLE: wait for `start`.
  - RD: read request outstanding.
  - WR: write request outstanding.
  - FIN: end-of-transfer cycle.
- IDLE → RD: `start`=1 and `length`≠0. Capture `src_addr`, `dst_addr` and `length` into internal registers `sp`, `dp`, `rem`. Clear `aborted`.
- IDLE → FIN: `start`=1 and `length`=0. No memory access is issued.
- RD behaviour:
  - Drive `read_enable`=1 and `address`=`sp`.
  - Hold both stable until `mem_finished`.
  - On `mem_finished`, latch `read_data` into `hold` and go to WR.
- WR behaviour:
  - Drive `write_enable`=1, `address`=`dp` and `write_data`=`hold`.
  - Hold all three until `mem_finished`.
  - On `mem_finished`: `sp`←`sp`+1, `dp`←`dp`+1 (both mod 2^ADDR_W), `rem`←`rem`−1.
  - Then go to FIN if `rem` becomes 0 or `abort` is latched; otherwise go to RD.
- FIN: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- `read_enable` and `write_enable` are never asserted together. Both are 0 in IDLE and FIN.
- Abort rules:
  - `abort` is latched internally whenever `busy`=1.
  - Abort during RD: the read completes, then go to FIN directly. The word is not written.
  - Abort during WR: the write completes, then go to FIN.
  - In both cases `aborted`←1.
  - `abort` in IDLE is ignored.
- Address wrap: 4095+1 = 0 for both pointers.
- `length`=4096 copies the entire field.
- Overlap: the copy always runs in ascending order, so a forward overlap (dst > src) propagates data. This behaviour is defined and tested.
- `mem_finished` seen in IDLE or FIN is ignored.
- `start` while `busy` is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `aborted`=0, `read_enable`=0, `write_enable`=0, `address`=0, `write_data`=0. All internal registers are 0.
- Reset mid-transfer returns to IDLE on the next edge. A pending memory response is then ignored.
- All outputs are registered.
- `start` accepted at edge N: `busy`=1 and `read_enable`=1 from cycle N+1.
- `mem_finished` at cycle M: the enable drops at M+1 and the next request's enable rises at M+1.
- Per word: 2 cycles plus the read and write latencies of the memory controller.
- `done` is asserted one cycle after the final write's `mem_finished`.

## Configuration
- Macro: `MEM_MOVER_CHECKSUM_EN`.
- Defined:
  - Adds output `checksum` (WORD_W), the 12-bit modular sum of all words written.
  - `checksum` is cleared on an accepted `start`, updated when each write completes, and held after FIN.
  - Reset value is 0.
- Undefined: no `checksum` port and no accumulator logic. All other behaviour is identical.

## Structure
- Shared package (CPU definitions package):
  - enum `Mover_states_t` {IDLE, RD, WR, FIN}.
  - Constants `MOVER_ADDR_W` and `MOVER_WORD_W`.
- Single module. No sub-module is needed; the FSM and the three counters are small.
- Connects to the memory controller through the `main_bus` address, data, enable and `mem_finished` signals. Bus arbitration is handled outside this block.

## Test plan
- Basic copy: mem[0100..0103]=1111,2222,3333,4444; src=0100, dst=0200, length=4 → mem[0200..0203] match, `done` pulses once, `busy` high throughout.
- Zero length: `length`=0 → `done` 1 cycle after `start`, no enables asserted, memory unchanged.
- Wrap: src=7776 (octal), dst=0010, length=4 → reads from 7776, 7777, 0000, 0001 (octal), writes to 0010..0013.
- Abort: length=8, `abort` during the 3rd read → exactly 2 words written, `aborted`=1, `done` pulses, the next `start` clears `aborted`.
- Reset mid-WR: enables drop on the next edge, `busy`=0, and a late `mem_finished` causes no state change.
- With `MEM_MOVER_CHECKSUM_EN`: copying 7777, 0001 (octal) → `checksum`=0000.
